// File: rtl/ibex_instr_bus_arbiter.sv
// Two-host arbiter for the shared instruction fetch port (req/gnt/rvalid, in-order responses).
// Owners of granted requests are queued so each response returns to the host that issued it.
module ibex_instr_bus_arbiter #(
  parameter int unsigned NumOutstanding = 2,
  parameter bit          RoundRobin     = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       host_req_i,
  input  logic [1:0][31:0] host_addr_i,
  output logic [1:0]       host_gnt_o,
  output logic [1:0]       host_rvalid_o,
  output logic [31:0]      host_rdata_o,
  output logic             host_err_o,
  output logic             instr_req_o,
  input  logic             instr_gnt_i,
  output logic [31:0]      instr_addr_o,
  input  logic             instr_rvalid_i,
  input  logic [31:0]      instr_rdata_i,
  input  logic             instr_err_i,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(NumOutstanding + 1);
  localparam int unsigned PtrW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;

  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic            fifo_q [NumOutstanding];
  logic            lock_q, lock_sel_q, last_q;
  logic            sel, pri, full, push, pop, head;

  assign pri = ~last_q;

  always_comb begin
    sel = 1'b0;
    if (lock_q) begin
      sel = lock_sel_q;
    end else if (RoundRobin) begin
      if (host_req_i[pri])       sel = pri;
      else if (host_req_i[~pri]) sel = ~pri;
      else                       sel = pri;
    end else begin
      sel = ~host_req_i[0] & host_req_i[1];
    end
  end

  // No bypass: a response arriving while full frees a slot only from the next cycle.
  assign full         = (count_q == CntW'(NumOutstanding));
  assign instr_req_o  = host_req_i[sel] & ~full;
  assign instr_addr_o = host_addr_i[sel];
  assign push         = instr_req_o & instr_gnt_i;
  assign pop          = instr_rvalid_i & (count_q != '0);
  assign head         = fifo_q[rd_ptr_q];

  assign host_gnt_o    = push ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign host_rvalid_o = pop ? (head ? 2'b10 : 2'b01) : 2'b00;
  assign host_rdata_o  = instr_rdata_i;
  assign host_err_o    = instr_err_i;
  assign busy_o        = (count_q != '0) | instr_req_o;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
      last_q     <= 1'b1;
      for (int i = 0; i < NumOutstanding; i++) fifo_q[i] <= 1'b0;
    end else begin
      count_q <= count_d;
      // Lock holds the selection (and thus the address) until granted; it also
      // falls away if the locked host withdraws, since instr_req_o is then low.
      lock_q  <= instr_req_o & ~instr_gnt_i;
      if (instr_req_o && !instr_gnt_i) lock_sel_q <= sel;
      if (push) begin
        last_q           <= sel;
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q <= (wr_ptr_q == PtrW'(NumOutstanding - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(NumOutstanding - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
    end
  end

  stray_rvalid_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> (count_q != '0));

  lock_drop_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> host_req_i[lock_sel_q]);

endmodule
